// File: rtl/tc141_flopx_arb_pkg.sv
// Shared types and constants for the tc141_flopx_arb holding-register arbiter.
//   state_e      : holding register state (empty / full)
//   clog2()      : index-width helper (never returns less than 1)
//   NREQ_MIN/MAX : legal range for the number of requesters
package tc141_flopx_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 16;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r++;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tc141_flopx_arb_if.sv
// Bus bundle between the requesters/downstream consumer and tc141_flopx_arb.
//   req    : per-requester request (level, held until granted)
//   reqdat : per-requester data, slice i = [i*WIDTH +: WIDTH]
//   gnt    : one-hot acceptance (combinational from the arbiter)
//   odat   : holding register contents
//   osrc   : index of requester whose data sits in odat
//   ovld   : holding register full
//   ordy   : downstream ready
//   lock   : per-requester burst lock (only with TC141_FLOPX_ARB_LOCK_EN)
// master modport: requester/consumer side; slave modport: the arbiter.
interface tc141_flopx_arb_if
  import tc141_flopx_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int SRCW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] reqdat;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      odat;
  logic [SRCW-1:0]       osrc;
  logic                  ovld;
  logic                  ordy;
`ifdef TC141_FLOPX_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;

  modport master (output req, reqdat, ordy, lock, input gnt, odat, osrc, ovld);
  modport slave  (input req, reqdat, ordy, lock, output gnt, odat, osrc, ovld);
`else
  modport master (output req, reqdat, ordy, input gnt, odat, osrc, ovld);
  modport slave  (input req, reqdat, ordy, output gnt, odat, osrc, ovld);
`endif

endinterface

// File: rtl/tc141_flopx_arb_rrpick.sv
// Combinational round-robin picker.
//   req  : eligible request vector
//   ptr  : highest-priority index for this search
//   pick : one-hot winner (first set bit at or after ptr, wrapping)
//   idx  : encoded winner index
//   any  : at least one request present
module tc141_rrpick #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [SRCW-1:0] idx,
  output logic            any
);

  logic [SRCW:0] cand;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr + i, folded back into 0..NREQ-1 (ptr is always < NREQ)
      cand = {1'b0, ptr} + (SRCW+1)'(i);
      if (cand >= (SRCW+1)'(NREQ)) cand = cand - (SRCW+1)'(NREQ);
      if (!any && req[cand[SRCW-1:0]]) begin
        any             = 1'b1;
        idx             = cand[SRCW-1:0];
        pick            = '0;
        pick[cand[SRCW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc141_flopx_arb.sv
// Round-robin arbiter feeding one WIDTH-bit holding register with a
// valid/ready output. The winner's data and index are captured; the
// round-robin pointer moves to the slot after the winner.
// Optional feature macro: TC141_FLOPX_ARB_LOCK_EN (burst lock per requester).
// Ports:
//   clk  : clock, rising edge
//   rst_ : synchronous active-low reset
//   bus  : tc141_flopx_arb_if.slave (req/reqdat/gnt/odat/osrc/ovld/ordy[/lock])
module tc141_flopx_arb
  import tc141_flopx_arb_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NREQ        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic               clk,
  input logic               rst_,
  tc141_flopx_arb_if.slave  bus
);

  localparam int SRCW = clog2(NREQ);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreq_bad
    $error("tc141_flopx_arb: NREQ out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] odat_q,  odat_d;
  logic [SRCW-1:0]  osrc_q,  osrc_d;
  logic [SRCW-1:0]  ptr_q,   ptr_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick;
  logic [SRCW-1:0]  pick_idx;
  logic [SRCW-1:0]  pick_nxt;
  logic             pick_any;
  logic             accept;
  logic [NREQ-1:0]  gnt;

`ifdef TC141_FLOPX_ARB_LOCK_EN
  logic             owner_vld_q, owner_vld_d;
  logic [SRCW-1:0]  owner_q,     owner_d;

  // While a burst owner exists, everyone else is masked out even if the
  // owner itself is currently idle.
  always_comb begin
    elig = bus.req;
    if (owner_vld_q) elig = bus.req & (NREQ'(1) << owner_q);
  end
`else
  always_comb elig = bus.req;
`endif

  tc141_rrpick #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_rrpick (
    .req  (elig),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_nxt = (pick_idx == SRCW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  // rst_ gates accept so gnt stays low throughout reset.
  assign accept = rst_ && pick_any && (state_q == ST_EMPTY || bus.ordy);

  always_comb begin
    state_d = state_q;
    odat_d  = odat_q;
    osrc_d  = osrc_q;
    ptr_d   = ptr_q;
    gnt     = '0;
`ifdef TC141_FLOPX_ARB_LOCK_EN
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
`endif

    if (state_q == ST_EMPTY) begin
      if (accept) state_d = ST_FULL;
    end else begin
      if (bus.ordy && !accept) state_d = ST_EMPTY;
    end

    if (accept) begin
      gnt    = pick;
      odat_d = bus.reqdat[pick_idx*WIDTH +: WIDTH];
      osrc_d = pick_idx;
`ifdef TC141_FLOPX_ARB_LOCK_EN
      // Pointer is frozen for the length of a burst and advances only
      // on the accept that releases the lock.
      if (bus.lock[pick_idx]) begin
        owner_vld_d = 1'b1;
        owner_d     = pick_idx;
      end else begin
        owner_vld_d = 1'b0;
        ptr_d       = pick_nxt;
      end
`else
      ptr_d = pick_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_EMPTY;
      odat_q  <= RESET_VALUE;
      osrc_q  <= '0;
      ptr_q   <= '0;
`ifdef TC141_FLOPX_ARB_LOCK_EN
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      odat_q  <= odat_d;
      osrc_q  <= osrc_d;
      ptr_q   <= ptr_d;
`ifdef TC141_FLOPX_ARB_LOCK_EN
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign bus.gnt  = gnt;
  assign bus.odat = odat_q;
  assign bus.osrc = osrc_q;
  assign bus.ovld = (state_q == ST_FULL);

endmodule

// File: tb/tb_tc141_flopx_arb.sv
// Testbench for tc141_flopx_arb: directed scenarios plus random traffic,
// compared against a transaction-level reference model.
module tb_tc141_flopx_arb;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic clk;
  logic rst_;

  tc141_flopx_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  tc141_flopx_arb #(
    .WIDTH       (WIDTH),
    .NREQ        (NREQ),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         m_full;
  logic [7:0] m_dat;
  int         m_src;
  int         m_ptr;
  int         m_own;   // -1 when no burst owner

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] r);
    if (m_own >= 0) return r[m_own] ? m_own : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_dat(input int i, input logic [7:0] d);
    bus.reqdat[i*WIDTH +: WIDTH] = d;
  endtask

  // Apply one cycle of stimulus, check gnt mid-cycle and the registered
  // outputs just after the edge.
  task automatic step(input logic [NREQ-1:0] r, input logic o,
                      input logic [NREQ-1:0] lk, input logic rv);
    int         w;
    bit         acc;
    logic [NREQ-1:0] eg;
    logic [7:0] wdat;
    bus.req  = r;
    bus.ordy = o;
    rst_     = rv;
`ifdef TC141_FLOPX_ARB_LOCK_EN
    bus.lock = lk;
`endif
    w    = model_winner(r);
    acc  = rv && (w >= 0) && (!m_full || o);
    eg   = acc ? (NREQ'(1) << w) : '0;
    wdat = acc ? bus.reqdat[w*WIDTH +: WIDTH] : 8'h00;
    @(negedge clk);
    check("gnt", 32'(bus.gnt), 32'(eg));
    @(posedge clk);
    #1;
    if (!rv) begin
      m_full = 0; m_dat = 8'h00; m_src = 0; m_ptr = 0; m_own = -1;
    end else if (acc) begin
      m_full = 1; m_dat = wdat; m_src = w;
`ifdef TC141_FLOPX_ARB_LOCK_EN
      if (lk[w]) m_own = w;
      else begin m_own = -1; m_ptr = (w + 1) % NREQ; end
`else
      m_ptr = (w + 1) % NREQ;
      if (lk != lk) m_ptr = 0;
`endif
    end else if (m_full && o) begin
      m_full = 0;
    end
    check("ovld", 32'(bus.ovld), 32'(m_full));
    check("odat", 32'(bus.odat), 32'(m_dat));
    check("osrc", 32'(bus.osrc), 32'(m_src));
  endtask

  initial begin
    m_full = 0; m_dat = 8'h00; m_src = 0; m_ptr = 0; m_own = -1;
    rst_       = 1'b0;
    bus.req    = '0;
    bus.ordy   = 1'b0;
    bus.reqdat = '0;
`ifdef TC141_FLOPX_ARB_LOCK_EN
    bus.lock   = '0;
`endif
    @(posedge clk);
    #1;

    // reset with all requesting; first accept after release goes to 0
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    check("rst_odat", 32'(bus.odat), 32'h00);
    for (int i = 0; i < NREQ; i++) set_dat(i, 8'hA0 + 8'(i));
    step(4'b1111, 1'b1, 4'b0000, 1'b1);
    check("first_src", 32'(bus.osrc), 32'd0);

    // round robin: continue 1,2,3,0
    for (int c = 0; c < 4; c++) step(4'b1111, 1'b1, 4'b0000, 1'b1);
    check("rr_wrap_dat", 32'(bus.odat), 32'hA0);

    // stall holding 55
    for (int i = 0; i < NREQ; i++) set_dat(i, 8'h55);
    step(4'b1111, 1'b1, 4'b0000, 1'b1);
    set_dat(1, 8'h3C);
    for (int c = 0; c < 5; c++) step(4'b0010, 1'b0, 4'b0000, 1'b1);
    check("stall_dat", 32'(bus.odat), 32'h55);
    step(4'b0010, 1'b1, 4'b0000, 1'b1);
    check("unstall_dat", 32'(bus.odat), 32'h3C);

    // sparse / wrap: drain, then single requesters
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b1000, 1'b1, 4'b0000, 1'b1);  // ptr -> 0
    step(4'b0100, 1'b1, 4'b0000, 1'b1);  // ptr -> 3
    step(4'b0001, 1'b1, 4'b0000, 1'b1);  // wrap to 0, ptr -> 1
    step(4'b1000, 1'b1, 4'b0000, 1'b1);  // 3, ptr -> 0
    check("wrap_src", 32'(bus.osrc), 32'd3);

    // reset mid-operation while full
    for (int i = 0; i < NREQ; i++) set_dat(i, 8'h77);
    step(4'b0001, 1'b1, 4'b0000, 1'b1);
    step(4'b1111, 1'b0, 4'b0000, 1'b0);
    check("midrst_ovld", 32'(bus.ovld), 32'd0);

`ifdef TC141_FLOPX_ARB_LOCK_EN
    // burst lock held by requester 2
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b0000, 1'b1);
    check("lock_src", 32'(bus.osrc), 32'd2);
    step(4'b1111, 1'b1, 4'b0000, 1'b1);
    check("unlock_src", 32'(bus.osrc), 32'd3);
`endif

    // random traffic
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] r;
      logic [NREQ-1:0] lk;
      for (int i = 0; i < NREQ; i++) set_dat(i, 8'($urandom));
      r  = NREQ'($urandom);
      lk = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      step(r, ($urandom_range(0, 3) != 0), lk, ($urandom_range(0, 63) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
